// File: rtl/dft_seq_if.sv
// dft_seq_if: datapath strobes and result write-back handshake between dft_sequencer (master) and the MAC datapath (slave)
interface dft_seq_if #(parameter int IDX_W = 12);
  logic fill_en;
  logic [IDX_W-1:0] n_index;
  logic [IDX_W-1:0] k_index;
  logic acc_en;
  logic acc_load;
  logic res_valid;
  logic res_ready;
  logic [IDX_W-1:0] res_addr;
  modport master(output fill_en, n_index, k_index, acc_en, acc_load, res_valid, res_addr, input res_ready);
  modport slave(input fill_en, n_index, k_index, acc_en, acc_load, res_valid, res_addr, output res_ready);
endinterface

// File: rtl/dft_sequencer.sv
// dft_sequencer: direct-DFT controller (RAM->cache fill, n/k sweep with pipeline-latency tokens, stalled write-back); DFT_SEQ_HALF_SPECTRUM_EN stops after bin N/2
module dft_sequencer #(
  parameter int IDX_W = 12,
  parameter int PIPE_LAT = 2
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  input logic [IDX_W-1:0] samp_last,
  input logic data_loaded,
  output logic busy,
  output logic done,
  dft_seq_if.master dp
);
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, FILL, MAC, DRAIN, WRITE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d, k_q, k_d, last_q, last_d, k_last;
  logic [PIPE_LAT-1:0] tv_q, tv_d, tl_q, tl_d;
  logic done_q, done_d;
  logic issue;
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
  assign k_last = IDX_W'(({1'b0, last_q} + 1'b1) >> 1);
`else
  assign k_last = last_q;
`endif
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    k_d = k_q;
    last_d = last_q;
    done_d = 1'b0;
    issue = state_q == MAC;
    tv_d = (tv_q << 1) | PIPE_LAT'(issue);
    tl_d = (tl_q << 1) | PIPE_LAT'(issue && n_q == '0);
    if (abort) begin
      state_d = IDLE;
      tv_d = '0;
      tl_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start && samp_last != '0) begin
          state_d = WAIT_LOAD;
          last_d = samp_last;
          n_d = '0;
          k_d = '0;
        end
        WAIT_LOAD: state_d = data_loaded ? FILL : WAIT_LOAD;
        FILL, MAC: begin
          n_d = n_q == last_q ? '0 : n_q + 1'b1;
          state_d = n_q != last_q ? state_q : state_q == FILL ? MAC : DRAIN;
        end
        DRAIN: state_d = tv_d == '0 ? WRITE : DRAIN;
        WRITE: if (dp.res_ready) begin
          state_d = k_q == k_last ? IDLE : MAC;
          done_d = k_q == k_last;
          k_d = k_q == k_last ? k_q : k_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      k_q <= '0;
      last_q <= '0;
      tv_q <= '0;
      tl_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      k_q <= k_d;
      last_q <= last_d;
      tv_q <= tv_d;
      tl_q <= tl_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign dp.fill_en = state_q == FILL;
  assign dp.n_index = n_q;
  assign dp.k_index = k_q;
  assign dp.acc_en = tv_q[PIPE_LAT-1];
  assign dp.acc_load = tl_q[PIPE_LAT-1];
  assign dp.res_valid = state_q == WRITE;
  assign dp.res_addr = k_q;
endmodule

// File: tb/tb_dft_sequencer.sv
// tb_dft_sequencer: directed + randomized checks of dft_sequencer against a cycle-timeline reference model
module tb_dft_sequencer;
  localparam int IDX_W = 12;
  localparam int PL = 2;
  typedef struct packed {
    logic busy;
    logic done;
    logic fill;
    logic [IDX_W-1:0] n;
    logic [IDX_W-1:0] k;
    logic ae;
    logic al;
    logic rv;
    logic [IDX_W-1:0] ra;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic data_loaded = 1'b0;
  logic busy, done;
  logic [IDX_W-1:0] samp_last = '0;
  int n_chk = 0;
  int n_fail = 0;
  obs_t o;
  dft_seq_if #(.IDX_W(IDX_W)) ifc();
  dft_sequencer #(.IDX_W(IDX_W), .PIPE_LAT(PL)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .samp_last(samp_last),
    .data_loaded(data_loaded),
    .busy(busy),
    .done(done),
    .dp(ifc)
  );
  assign o = {busy, done, ifc.fill_en, ifc.n_index, ifc.k_index, ifc.acc_en, ifc.acc_load, ifc.res_valid, ifc.res_addr};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int cyc, input obs_t got, input obs_t exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @%0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic chk_bit(input string tag, input int cyc, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @%0d: observed %b expected %b", tag, cyc, got, exp);
    end
  endtask
  task automatic run_case(input int n_smp, input int dly, input bit rnd, input int stall_bin, input int stall_len, input bit noise);
    obs_t q[$];
    bit iss[$];
    bit rr[0:4095];
    obs_t e;
    int klast, sc;
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    klast = n_smp / 2;
`else
    klast = n_smp - 1;
`endif
    foreach (rr[i]) rr[i] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    e = '0;
    e.busy = 1'b1;
    repeat (dly) begin q.push_back(e); iss.push_back(1'b0); end
    for (int n = 0; n < n_smp; n++) begin
      e.fill = 1'b1;
      e.n = IDX_W'(n);
      q.push_back(e);
      iss.push_back(1'b0);
    end
    e.fill = 1'b0;
    for (int k = 0; k <= klast; k++) begin
      e.k = IDX_W'(k);
      e.ra = IDX_W'(k);
      for (int n = 0; n < n_smp; n++) begin
        e.n = IDX_W'(n);
        q.push_back(e);
        iss.push_back(1'b1);
      end
      e.n = '0;
      repeat (PL) begin q.push_back(e); iss.push_back(1'b0); end
      e.rv = 1'b1;
      sc = 0;
      do begin
        if (k == stall_bin && sc < stall_len) rr[q.size()] = 1'b0;
        q.push_back(e);
        iss.push_back(1'b0);
        sc++;
      end while (!rr[q.size() - 1]);
      e.rv = 1'b0;
    end
    e.busy = 1'b0;
    e.done = 1'b1;
    q.push_back(e);
    iss.push_back(1'b0);
    e.done = 1'b0;
    q.push_back(e);
    iss.push_back(1'b0);
    for (int i = PL; i < q.size(); i++) if (iss[i-PL]) begin
      q[i].ae = 1'b1;
      q[i].al = q[i-PL].n == '0;
    end
    samp_last = IDX_W'(n_smp - 1);
    data_loaded = dly == 1;
    start = 1'b1;
    for (int j = 0; j < q.size(); j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("run_n%0d", n_smp), j, o, q[j]);
      start = noise && j < q.size() - 2 && $urandom_range(0, 3) == 0;
      if (noise) samp_last = IDX_W'($urandom);
      data_loaded = j >= dly - 1;
      ifc.res_ready = rr[j];
    end
    start = 1'b0;
    data_loaded = 1'b0;
    ifc.res_ready = 1'b1;
  endtask
  initial begin
    int w;
    ifc.res_ready = 1'b1;
    #12;
    chk("reset", 0, o, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    samp_last = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_bit("n0_ignored", 0, busy, 1'b0);
    run_case(4, 1, 1'b0, -1, 0, 1'b0);
    run_case(4, 2, 1'b0, 1, 5, 1'b0);
    run_case(8, 11, 1'b0, -1, 0, 1'b1);
    run_case(2, 1, 1'b1, -1, 0, 1'b1);
    repeat (5) run_case($urandom_range(2, 10), $urandom_range(1, 4), 1'b1, $urandom_range(0, 1), $urandom_range(0, 4), 1'b1);
    samp_last = IDX_W'(7);
    start = 1'b1;
    data_loaded = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (!(ifc.fill_en && ifc.n_index == IDX_W'(2)) && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk_bit("abort_reach", w, ifc.fill_en && ifc.n_index == IDX_W'(2), 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    data_loaded = 1'b0;
    chk_bit("abort_busy", 0, busy, 1'b0);
    chk_bit("abort_acc", 0, ifc.acc_en, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk_bit("abort_fill", i, ifc.fill_en, 1'b0);
      chk_bit("abort_done", i, done, 1'b0);
      @(posedge clk);
      #1;
    end
    samp_last = IDX_W'(7);
    start = 1'b1;
    data_loaded = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (!(ifc.k_index == IDX_W'(3) && ifc.acc_en) && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk_bit("mac_k3_reach", w, ifc.k_index == IDX_W'(3) && ifc.acc_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("reset_mid_mac", 0, o, '0);
    rst = 1'b0;
    data_loaded = 1'b0;
    run_case(8, 1, 1'b1, 3, 2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dft_sequencer.md
# dft_sequencer

Controller for the direct-DFT MAC datapath: sequences the sample RAM → cache copy, the n/k index sweep that drives the cache, twiddle ROM and accumulator, and the write-back of each finished bin to RAM. Replaces the separate loose FSM/counter pair with one block that owns all datapath enables. It also compensates for a fixed read-to-accumulate pipeline latency and stalls the sweep on write-back backpressure.

## Interface
Parameters:
- IDX_W, 12, width of sample/bin indices.
- PIPE_LAT, 2, cycles from `n_index` change to that term at the accumulator input (1..4).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- abort  in  1  drop current transform, return to IDLE
- samp_last  in  IDX_W  N-1, index of last sample; legal 1..2^IDX_W-1, latched at start
- data_loaded  in  1  AXI side has finished filling sample RAM
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when last bin accepted
- fill_en  out  1  RAM→cache copy strobe (RAM read + cache write)
- n_index  out  IDX_W  sample index to RAM/cache/twiddle ROM
- k_index  out  IDX_W  bin index to twiddle ROM and result address
- acc_en  out  1  accumulator clock enable
- acc_load  out  1  with acc_en: load term instead of add (first term of a bin)
- res_valid  out  1  accumulated bin ready for write-back
- res_ready  in  1  RAM accepts write-back
- res_addr  out  IDX_W  write-back address (= bin index)

## Operation
- States: IDLE, WAIT_LOAD, FILL, MAC, DRAIN, WRITE.
- IDLE: start=1 → latch samp_last, clear n/k → WAIT_LOAD.
- WAIT_LOAD: wait data_loaded=1 → FILL (same-cycle data_loaded does not skip the state).
- FILL: fill_en=1, n_index counts 0..samp_last one per cycle; after samp_last → n_index=0, MAC.
- MAC: n_index counts 0..samp_last one per cycle at current k_index; each issued index pushes a token into a PIPE_LAT-deep shift register; token exits → acc_en=1, acc_load=1 for n=0 token. After issuing samp_last → DRAIN.
- DRAIN: wait until shift register empty (PIPE_LAT cycles) → WRITE.
- WRITE: res_valid=1, res_addr=k_index held stable until res_ready. On handshake: if k_index==k_last → done pulse, IDLE; else k_index+1, n_index=0, MAC.
- k_last = samp_last (full spectrum) or see Configuration.
- Counters wrap only via explicit clear; never free-run past samp_last.
- abort in any state → IDLE next cycle, shift register flushed, all strobes low; no done.
- start while busy ignored. samp_last=0 at start: treated as illegal, block stays IDLE.

## Timing
- Reset values: busy=0, done=0, fill_en=0, n_index=0, k_index=0, acc_en=0, acc_load=0, res_valid=0, res_addr=0.
- FILL lasts exactly N cycles.
- Per bin: N issue cycles + PIPE_LAT drain + ≥1 WRITE cycle; with res_ready tied high, bin period = N+PIPE_LAT+1 cycles.
- acc_en for index n appears exactly PIPE_LAT cycles after n_index=n is presented.
- res_valid rises the cycle after last acc_en; falls the cycle after handshake.
- done asserted on the cycle after final handshake; busy falls same cycle.
- All outputs registered; no combinational path input→output except none (res_ready affects next cycle only).

## Configuration
- DFT_SEQ_HALF_SPECTRUM_EN defined: k_last = floor(N/2) = (samp_last+1)>>1; bins above N/2 not computed (real-input symmetry).
- Undefined: k_last = samp_last, all N bins computed.

## Test plan
- Reset mid-MAC (N=8, k=3): assert rst → all outputs at reset values immediately; next start runs from k=0.
- N=4, PIPE_LAT=2, res_ready=1: FILL 4 cycles, each bin 7 cycles, acc_load pulses on 4 bins, res_addr 0,1,2,3, done once.
- res_ready held low 5 cycles at bin 1: res_valid/res_addr=1 stable, n_index frozen, no acc_en; resumes on res_ready.
- data_loaded delayed 10 cycles after start: stays WAIT_LOAD, fill_en=0 throughout, busy=1.
- abort during FILL at n=2: next cycle IDLE, busy=0, no done, no further fill_en.
- DFT_SEQ_HALF_SPECTRUM_EN, N=8: res_addr sequence 0..4, done after bin 4; undefined: 0..7.
